// File: rtl/fpu_bus_interface_if.sv
// CPU byte bus plus FPU core handshake bundle for fpu_bus_interface.
// The irq signal only exists when FPU_BUS_IRQ_EN is defined.
interface fpu_bus_interface_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              cs;
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wr_data;
  logic [7:0]        rd_data;
  logic [31:0]       fpu_operand_a;
  logic [31:0]       fpu_operand_b;
  logic [3:0]        fpu_op;
  logic              fpu_start;
  logic              fpu_end;
  logic [31:0]       fpu_result;
  logic              fpu_ack;
`ifdef FPU_BUS_IRQ_EN
  logic              irq;
`endif

  // Register-window side (the design under this bus)
  modport slave (
    input  cs, wr, rd, addr, wr_data, fpu_end, fpu_result,
`ifdef FPU_BUS_IRQ_EN
    output irq,
`endif
    output rd_data, fpu_operand_a, fpu_operand_b, fpu_op, fpu_start, fpu_ack
  );

  // CPU and FPU core side driving the window
  modport master (
    output cs, wr, rd, addr, wr_data, fpu_end, fpu_result,
`ifdef FPU_BUS_IRQ_EN
    input  irq,
`endif
    input  rd_data, fpu_operand_a, fpu_operand_b, fpu_op, fpu_start, fpu_ack
  );
endinterface

// File: rtl/fpu_bus_interface.sv
// Byte-wide CPU register window in front of the FPU core: assembles operands
// and opcode, runs the start/end/ack handshake, captures the result.
// Optional macro FPU_BUS_IRQ_EN adds the irq output and the irq_en control bit.
module fpu_bus_interface #(
  parameter int unsigned NUM_OPS = 13,
  parameter int unsigned ADDR_W  = 4
) (
  input  logic                 clk,
  input  logic                 arst_n,
  fpu_bus_interface_if.slave   bus
);

  localparam logic [ADDR_W-1:0] ADDR_CMD    = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(9);
  localparam logic [ADDR_W-1:0] ADDR_RES0   = ADDR_W'(10);
  localparam logic [ADDR_W-1:0] ADDR_RES3   = ADDR_W'(13);
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(14);
  localparam logic [ADDR_W-1:0] ADDR_OPB0   = ADDR_W'(4);

  typedef enum logic [1:0] {
    IF_IDLE_ST     = 2'd0,
    IF_WAIT_END_ST = 2'd1,
    IF_WAIT_ACK_ST = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] opnd_a;
  logic [31:0] opnd_b;
  logic [3:0]  op;
  logic [31:0] result;
  logic        done;
  logic        error;
  logic        start;
  logic        ack;
  logic [7:0]  rd_q;
  logic        irq_en_bit;
`ifdef FPU_BUS_IRQ_EN
  logic        irq_en;
  logic        irq_q;
`endif

  logic        wr_en;
  logic        rd_en;
  logic        busy;
  logic        is_opnd;
  logic        is_cmd;
  logic        is_ctrl;
  logic        op_ok;
  logic        cmd_go;
  logic        err_set;
  logic        err_clr;
  logic        done_set;
  logic        done_clr;
  logic        opnd_wr;
  logic [7:0]  rd_mux;
  logic [1:0]  res_sel;

  // Bus decode and event qualification
  always_comb begin
    wr_en    = bus.cs & bus.wr;
    rd_en    = bus.cs & bus.rd;
    busy     = (state != IF_IDLE_ST);
    is_opnd  = (bus.addr < ADDR_CMD);
    is_cmd   = (bus.addr == ADDR_CMD);
    is_ctrl  = (bus.addr == ADDR_CTRL);
    op_ok    = (32'(bus.wr_data[3:0]) < NUM_OPS);
    cmd_go   = wr_en & is_cmd & ~busy & op_ok;
    opnd_wr  = wr_en & is_opnd & ~busy;
    err_set  = wr_en & ((busy & (is_opnd | is_cmd)) | (~busy & is_cmd & ~op_ok));
    err_clr  = wr_en & is_ctrl & bus.wr_data[0];
    done_set = (state == IF_WAIT_ACK_ST) & ~bus.fpu_end;
    done_clr = rd_en & (bus.addr == ADDR_RES3);
  end

`ifdef FPU_BUS_IRQ_EN
  assign irq_en_bit = irq_en;
`else
  assign irq_en_bit = 1'b0;
`endif

  // Read-data multiplexer for the register window
  always_comb begin
    rd_mux  = 8'h00;
    res_sel = 2'(bus.addr - ADDR_RES0);
    if (bus.addr < ADDR_OPB0) begin
      rd_mux = opnd_a[8*bus.addr[1:0] +: 8];
    end else if (is_opnd) begin
      rd_mux = opnd_b[8*bus.addr[1:0] +: 8];
    end else if (is_cmd) begin
      rd_mux = {4'h0, op};
    end else if (bus.addr == ADDR_STATUS) begin
      rd_mux = {4'h0, irq_en_bit, error, done, busy};
    end else if ((bus.addr >= ADDR_RES0) && (bus.addr <= ADDR_RES3)) begin
      rd_mux = result[8*res_sel +: 8];
    end
  end

  // Registers, status flags and the launch/handshake FSM
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state  <= IF_IDLE_ST;
      opnd_a <= 32'h0;
      opnd_b <= 32'h0;
      op     <= 4'h0;
      result <= 32'h0;
      done   <= 1'b0;
      error  <= 1'b0;
      start  <= 1'b0;
      ack    <= 1'b0;
      rd_q   <= 8'h00;
`ifdef FPU_BUS_IRQ_EN
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
`endif
    end else begin
      if (rd_en) rd_q <= rd_mux;

      if (opnd_wr && (bus.addr < ADDR_OPB0)) opnd_a[8*bus.addr[1:0] +: 8] <= bus.wr_data;
      if (opnd_wr && (bus.addr >= ADDR_OPB0)) opnd_b[8*bus.addr[1:0] +: 8] <= bus.wr_data;

      // Setting wins over clearing for both sticky flags
      if (err_set)                 error <= 1'b1;
      else if (err_clr)            error <= 1'b0;
      if (done_set)                done  <= 1'b1;
      else if (cmd_go || done_clr) done  <= 1'b0;

`ifdef FPU_BUS_IRQ_EN
      if (wr_en && is_ctrl && bus.wr_data[1]) irq_en <= 1'b1;
      irq_q <= done & irq_en;
`endif

      case (state)
        IF_IDLE_ST: begin
          if (cmd_go) begin
            op    <= bus.wr_data[3:0];
            start <= 1'b1;
            state <= IF_WAIT_END_ST;
          end
        end
        IF_WAIT_END_ST: begin
          if (bus.fpu_end) begin
            result <= bus.fpu_result;
            start  <= 1'b0;
            ack    <= 1'b1;
            state  <= IF_WAIT_ACK_ST;
          end
        end
        IF_WAIT_ACK_ST: begin
          if (!bus.fpu_end) begin
            ack   <= 1'b0;
            state <= IF_IDLE_ST;
          end
        end
        default: state <= IF_IDLE_ST;
      endcase
    end
  end

  assign bus.rd_data       = rd_q;
  assign bus.fpu_operand_a = opnd_a;
  assign bus.fpu_operand_b = opnd_b;
  assign bus.fpu_op        = op;
  assign bus.fpu_start     = start;
  assign bus.fpu_ack       = ack;
`ifdef FPU_BUS_IRQ_EN
  assign bus.irq           = irq_q;
`endif

endmodule
